// File: rtl/pipe_cla_adder_if.sv
`default_nettype none
//============================================================================
// Module : pipe_cla_adder_if
// Desc   : Operand/result handshake bundle for the pipelined CLA adder.
//          master = operand producer / result consumer, slave = the adder.
// Rev    : 1.0  initial release
//============================================================================
interface pipe_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             pg;
    logic             gg;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, pg, gg
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, pg, gg
    );
endinterface
`default_nettype wire

// File: rtl/pipe_cla_adder.sv
`default_nettype none
//============================================================================
// Module : pipe_cla_adder
// Desc   : Elastic pipelined adder/subtractor built from 4-bit carry-lookahead
//          groups. Groups are split into PIPE contiguous stages (low groups
//          first); each stage does a second-level lookahead over its groups.
// Rev    : 1.0  initial release
//============================================================================
module pipe_cla_adder #(
    parameter int WIDTH = 16,
    parameter int PIPE  = 2
) (
    input  wire             clk,
    input  wire             rst_n,
    pipe_cla_adder_if.slave bus
);
    localparam int c_ngrp = WIDTH / 4;

    // First group index handled by stage s; earlier stages absorb the remainder.
    function automatic int grp_start(input int s);
        grp_start = s * (c_ngrp / PIPE) + ((s < (c_ngrp % PIPE)) ? s : (c_ngrp % PIPE));
    endfunction

    // Subtraction is folded into the operands at entry, so each transaction
    // carries its own mode down the pipe inside b_eff/c0.
    logic [WIDTH-1:0] w_beff;
    logic             w_c0;
    assign w_beff = bus.sub ? ~bus.b : bus.b;
    assign w_c0   = bus.sub | bus.cin;

    logic [PIPE-1:0] r_valid;
    logic [PIPE-1:0] w_open;
    logic [PIPE:0]   w_chain;
    logic [PIPE-1:0] w_take;

    // w_chain[k] is the valid bit feeding stage k; the top entry is the output.
    assign w_chain       = {r_valid, bus.in_valid};
    assign w_take        = w_open & w_chain[PIPE-1:0];
    assign bus.in_ready  = rst_n & w_open[0];
    assign bus.out_valid = w_chain[PIPE];

    // A stage can load when it is empty or its contents leave this cycle.
    always_comb begin
        logic w_space;
        w_space = bus.out_ready;
        w_open  = '0;
        for (int k = PIPE - 1; k >= 0; k--) begin
            w_open[k] = !r_valid[k] || w_space;
            w_space   = w_open[k];
        end
    end

    // Stage occupancy: each open stage takes the valid bit of its source.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else begin
            for (int k = 0; k < PIPE; k++) begin
                if (w_open[k]) begin
                    r_valid[k] <= w_chain[k];
                end
            end
        end
    end

    for (genvar k = 0; k < PIPE; k++) begin : g_stage
        localparam int c_lo  = grp_start(k);
        localparam int c_ng  = grp_start(k + 1) - c_lo;
        localparam int c_lob = 4 * c_lo;
        localparam int c_rem = WIDTH - c_lob;

        // Stage inputs: unprocessed operand bits (bit 0 = word bit c_lob),
        // carry into this stage, partial sum and running whole-word P/G.
        logic [c_rem-1:0] w_a_in;
        logic [c_rem-1:0] w_b_in;
        logic [WIDTH-1:0] w_sum_in;
        logic             w_c_in;
        logic             w_p_in;
        logic             w_g_in;

        logic [WIDTH-1:0] r_sum;
        logic             r_c;
        logic             r_p;
        logic             r_g;

        if (k == 0) begin : g_head
            assign w_a_in   = bus.a;
            assign w_b_in   = w_beff;
            assign w_c_in   = w_c0;
            assign w_sum_in = '0;
            assign w_p_in   = 1'b1;
            assign w_g_in   = 1'b0;
        end else begin : g_link
            assign w_a_in   = g_stage[k-1].g_fwd.r_a;
            assign w_b_in   = g_stage[k-1].g_fwd.r_b;
            assign w_c_in   = g_stage[k-1].r_c;
            assign w_sum_in = g_stage[k-1].r_sum;
            assign w_p_in   = g_stage[k-1].r_p;
            assign w_g_in   = g_stage[k-1].r_g;
        end

        logic [4*c_ng-1:0] w_p;
        logic [4*c_ng-1:0] w_g;
        logic [4*c_ng-1:0] w_s;
        logic [c_ng-1:0]   w_gp;
        logic [c_ng-1:0]   w_gg;
        logic [c_ng:0]     w_cg;
        logic [WIDTH-1:0]  w_sum_out;
        logic              w_p_out;
        logic              w_g_out;

        // Group P/G, lookahead carries across groups, group sums, running P/G.
        always_comb begin
            logic w_term;
            w_term = 1'b0;
            w_p    = w_a_in[4*c_ng-1:0] ^ w_b_in[4*c_ng-1:0];
            w_g    = w_a_in[4*c_ng-1:0] & w_b_in[4*c_ng-1:0];
            for (int j = 0; j < c_ng; j++) begin
                w_gp[j] = &w_p[4*j +: 4];
                w_gg[j] = w_g[4*j+3]
                        | (w_p[4*j+3] & w_g[4*j+2])
                        | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
                        | ((&w_p[4*j+1 +: 3]) & w_g[4*j]);
            end
            // Second level: carry into group j as a flat sum of products.
            w_cg    = '0;
            w_cg[0] = w_c_in;
            for (int j = 1; j <= c_ng; j++) begin
                w_cg[j] = w_c_in;
                for (int m = 0; m < j; m++) begin
                    w_cg[j] = w_cg[j] & w_gp[m];
                end
                for (int m = 0; m < j; m++) begin
                    w_term = w_gg[m];
                    for (int n = m + 1; n < j; n++) begin
                        w_term = w_term & w_gp[n];
                    end
                    w_cg[j] = w_cg[j] | w_term;
                end
            end
            for (int j = 0; j < c_ng; j++) begin
                w_s[4*j]   = w_p[4*j] ^ w_cg[j];
                w_s[4*j+1] = w_p[4*j+1] ^ (w_g[4*j] | (w_p[4*j] & w_cg[j]));
                w_s[4*j+2] = w_p[4*j+2] ^ (w_g[4*j+1]
                           | (w_p[4*j+1] & w_g[4*j])
                           | (w_p[4*j+1] & w_p[4*j] & w_cg[j]));
                w_s[4*j+3] = w_p[4*j+3] ^ (w_g[4*j+2]
                           | (w_p[4*j+2] & w_g[4*j+1])
                           | (w_p[4*j+2] & w_p[4*j+1] & w_g[4*j])
                           | (w_p[4*j+2] & w_p[4*j+1] & w_p[4*j] & w_cg[j]));
            end
            w_p_out = w_p_in;
            w_g_out = w_g_in;
            for (int j = 0; j < c_ng; j++) begin
                w_g_out = w_gg[j] | (w_gp[j] & w_g_out);
                w_p_out = w_p_out & w_gp[j];
            end
            w_sum_out = w_sum_in;
            w_sum_out[c_lob +: 4*c_ng] = w_s;
        end

        // Stage result registers, loaded only when a valid item enters.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_sum <= '0;
                r_c   <= 1'b0;
                r_p   <= 1'b0;
                r_g   <= 1'b0;
            end else if (w_take[k]) begin
                r_sum <= w_sum_out;
                r_c   <= w_cg[c_ng];
                r_p   <= w_p_out;
                r_g   <= w_g_out;
            end
        end

        if (k < PIPE - 1) begin : g_fwd
            logic [c_rem-4*c_ng-1:0] r_a;
            logic [c_rem-4*c_ng-1:0] r_b;

            // Forward only the operand bits later stages still need.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_take[k]) begin
                    r_a <= w_a_in[c_rem-1:4*c_ng];
                    r_b <= w_b_in[c_rem-1:4*c_ng];
                end
            end
        end else begin : g_last
            logic w_ovf;
            logic r_ovf;
            assign w_ovf = (w_a_in[c_rem-1] == w_b_in[c_rem-1])
                        && (w_sum_out[WIDTH-1] != w_a_in[c_rem-1]);

            // Signed overflow is resolved where the MSB group is summed.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_take[k]) begin
                    r_ovf <= w_ovf;
                end
            end
        end
    end

    assign bus.sum  = g_stage[PIPE-1].r_sum;
    assign bus.cout = g_stage[PIPE-1].r_c;
    assign bus.pg   = g_stage[PIPE-1].r_p;
    assign bus.gg   = g_stage[PIPE-1].r_g;
    assign bus.ovf  = g_stage[PIPE-1].g_last.r_ovf;
endmodule
`default_nettype wire
